cache_line_mover: RTL and testbench
===================================

Name: cache_line_mover

Overview:
Line-transfer engine on the initiator side of the cache data RAM. It drives the RAM write port and read port.
- Refill: streams one cache line from the memory side into the RAM.
- Writeback: reads one line out of the RAM and streams it to the memory side.
- One request is in flight at a time. The engine is the sole master of the RAM ports while busy.

Parameters:
DATA_WIDTH, 32, word width of RAM and memory streams (multiple of 8)
ADDR_WIDTH, 5, RAM word-address width
OFFSET_BITS, 2, log2(words per line); WORDS = 1<<OFFSET_BITS
DATA_BYTE_NUM, DATA_WIDTH/8, byte-enable width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  engine idle, can accept a request
req_op  in  1  0 = refill, 1 = writeback
req_line  in  ADDR_WIDTH-OFFSET_BITS  line index
done  out  1  one-cycle pulse: request complete
mem_in_valid  in  1  refill beat valid
mem_in_ready  out  1  refill beat accepted
mem_in_data  in  DATA_WIDTH  refill word
mem_out_valid  out  1  writeback beat valid
mem_out_ready  in  1  memory side accepts beat
mem_out_data  out  DATA_WIDTH  writeback word
mem_out_last  out  1  final beat of line
ram_wr_en  out  1  RAM write strobe
ram_wr_addr  out  ADDR_WIDTH  RAM write address
ram_wr_data  out  DATA_WIDTH  RAM write data
ram_wr_byte_en  out  DATA_BYTE_NUM  RAM byte enables
ram_rd_addr  out  ADDR_WIDTH  RAM read address
ram_rd_data  in  DATA_WIDTH  RAM read data, valid one cycle after ram_rd_addr

Behaviour:
- States: IDLE, FILL, WB_RD, WB_LAT, WB_SEND, DONE.
- Registers: state, line_q, cnt (OFFSET_BITS bits), out_q (DATA_WIDTH).
- Reset (rst_n low at a clk edge): state=IDLE, cnt=0, line_q=0, out_q=0.
  - All outputs are 0 while in reset and in IDLE, except req_ready.
  - req_ready = (state==IDLE) && rst_n.
- Reset mid-operation: IDLE at the next edge. No done pulse. RAM words already written remain written.
- IDLE:
  - Request accepted on req_valid && req_ready.
  - req_line is latched into line_q and cnt is cleared.
  - Next state is FILL (op 0) or WB_RD (op 1).
- FILL:
  - mem_in_ready=1.
  - ram_wr_en = mem_in_valid (combinational).
  - ram_wr_addr = {line_q, cnt}.
  - ram_wr_data = mem_in_data.
  - ram_wr_byte_en = all ones.
  - Each accepted beat increments cnt. On the beat with cnt==WORDS-1, cnt wraps to 0 and the next state is DONE.
  - No write is issued on cycles where mem_in_valid=0.
- WB_RD: ram_rd_addr = {line_q, cnt}. Next state WB_LAT.
- WB_LAT:
  - ram_rd_addr is held.
  - ram_rd_data is captured into out_q.
  - Next state WB_SEND.
- WB_SEND:
  - mem_out_valid=1, mem_out_data=out_q, mem_out_last=(cnt==WORDS-1).
  - Data and last are held stable until mem_out_ready.
  - On handshake, cnt increments; the next state is DONE if last, else WB_RD.
- DONE: done=1 for exactly one cycle. Next state IDLE.
- Outside their active states, mem_in_ready, mem_out_valid, mem_out_last, ram_wr_en and done are 0. ram_*_addr and data are 0 in IDLE.
- Input handling:
  - mem_in_valid outside FILL is ignored; no RAM write.
  - req_valid while busy is ignored; req_ready=0 while busy.
- Latency with no stalls, request handshake at cycle 0:
  - Refill: beats at cycles 1..WORDS, done at cycle WORDS+1, req_ready at cycle WORDS+2.
  - Writeback: word k on mem_out at cycle 3+3k, done at cycle 3*WORDS+1.
- Address arithmetic: {line_q, cnt} is a concatenation only. Lines never cross a boundary, and the last line (all ones) wraps cnt within the line.

Test Plan:
- Refill line 3 with words 0xA0..0xA3, mem_in_valid constant 1 -> RAM writes at addr 12..15 in cycles 1..4, byte_en=0xF, done at cycle 5, req_ready=1 at cycle 6.
- Refill with valid gaps (valid pattern 1,0,0,1,1,0,1) -> exactly 4 writes to consecutive addresses, no writes on gap cycles, done the cycle after the 4th beat.
- Writeback line 7 preloaded 0x11..0x44, ready constant 1 -> mem_out_data 0x11,0x22,0x33,0x44 at cycles 3,6,9,12; last only with 0x44; done at cycle 13.
- Writeback with mem_out_ready low for 5 cycles on beat 2 -> valid, data and last stay stable; no extra or missing beats; ram_rd_addr does not advance during the stall.
- Reset driven low during beat 2 of a refill -> IDLE next edge, no done, only addr line*4+0 and +1 written; a new request is accepted after release.
- req_valid pulsed while a writeback is busy, and mem_in_valid driven in IDLE -> ignored; no RAM write, req_ready stays 0 until IDLE.

Source files
------------

// File: rtl/cache_line_mover_if.sv
// Request, memory-stream and RAM-port signals of the cache line mover.
// The engine side uses modport master; the environment side uses slave.
interface cache_line_mover_if #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDR_WIDTH    = 5,
  parameter int unsigned OFFSET_BITS   = 2,
  parameter int unsigned DATA_BYTE_NUM = DATA_WIDTH / 8
);
  logic                              req_valid;
  logic                              req_ready;
  logic                              req_op;
  logic [ADDR_WIDTH-OFFSET_BITS-1:0] req_line;
  logic                              done;
  logic                              mem_in_valid;
  logic                              mem_in_ready;
  logic [DATA_WIDTH-1:0]             mem_in_data;
  logic                              mem_out_valid;
  logic                              mem_out_ready;
  logic [DATA_WIDTH-1:0]             mem_out_data;
  logic                              mem_out_last;
  logic                              ram_wr_en;
  logic [ADDR_WIDTH-1:0]             ram_wr_addr;
  logic [DATA_WIDTH-1:0]             ram_wr_data;
  logic [DATA_BYTE_NUM-1:0]          ram_wr_byte_en;
  logic [ADDR_WIDTH-1:0]             ram_rd_addr;
  logic [DATA_WIDTH-1:0]             ram_rd_data;

  modport master (
    input  req_valid, req_op, req_line, mem_in_valid, mem_in_data, mem_out_ready, ram_rd_data,
    output req_ready, done, mem_in_ready, mem_out_valid, mem_out_data, mem_out_last,
    output ram_wr_en, ram_wr_addr, ram_wr_data, ram_wr_byte_en, ram_rd_addr
  );

  modport slave (
    output req_valid, req_op, req_line, mem_in_valid, mem_in_data, mem_out_ready, ram_rd_data,
    input  req_ready, done, mem_in_ready, mem_out_valid, mem_out_data, mem_out_last,
    input  ram_wr_en, ram_wr_addr, ram_wr_data, ram_wr_byte_en, ram_rd_addr
  );
endinterface

// File: rtl/cache_line_mover.sv
// Moves one cache line between the memory streams and the data RAM: refill writes a line,
// writeback reads a line out through a one-cycle-latency read port.
module cache_line_mover #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDR_WIDTH    = 5,
  parameter int unsigned OFFSET_BITS   = 2,
  parameter int unsigned DATA_BYTE_NUM = DATA_WIDTH / 8
) (
  input logic               clk,
  input logic               rst_n,
  cache_line_mover_if.master bus
);
  localparam int unsigned LineWidth = ADDR_WIDTH - OFFSET_BITS;
  localparam logic [OFFSET_BITS-1:0] CntLast = '1;

  typedef enum logic [2:0] {StIdle, StFill, StWbRd, StWbLat, StWbSend, StDone} state_e;

  state_e                  state_q, state_d;
  logic [LineWidth-1:0]    line_q, line_d;
  logic [OFFSET_BITS-1:0]  cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   out_q, out_d;
  logic [ADDR_WIDTH-1:0]   addr;

  // Lines never straddle a boundary: the count wraps inside the line.
  assign addr = {line_q, cnt_q};

  always_comb begin
    state_d = state_q;
    line_d  = line_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          line_d  = bus.req_line;
          cnt_d   = '0;
          state_d = bus.req_op ? StWbRd : StFill;
        end
      end
      StFill: begin
        if (bus.mem_in_valid) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CntLast) state_d = StDone;
        end
      end
      StWbRd:  state_d = StWbLat;
      StWbLat: begin
        out_d   = bus.ram_rd_data;
        state_d = StWbSend;
      end
      StWbSend: begin
        if (bus.mem_out_ready) begin
          cnt_d   = cnt_q + 1'b1;
          state_d = (cnt_q == CntLast) ? StDone : StWbRd;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      line_q  <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      line_q  <= line_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
    end
  end

  // Everything except req_ready is forced quiet while reset is asserted.
  always_comb begin
    bus.req_ready      = rst_n && (state_q == StIdle);
    bus.done           = 1'b0;
    bus.mem_in_ready   = 1'b0;
    bus.mem_out_valid  = 1'b0;
    bus.mem_out_data   = '0;
    bus.mem_out_last   = 1'b0;
    bus.ram_wr_en      = 1'b0;
    bus.ram_wr_addr    = '0;
    bus.ram_wr_data    = '0;
    bus.ram_wr_byte_en = '0;
    bus.ram_rd_addr    = '0;
    if (rst_n) begin
      case (state_q)
        StFill: begin
          bus.mem_in_ready   = 1'b1;
          bus.ram_wr_en      = bus.mem_in_valid;
          bus.ram_wr_addr    = addr;
          bus.ram_wr_data    = bus.mem_in_data;
          bus.ram_wr_byte_en = '1;
        end
        StWbRd, StWbLat: bus.ram_rd_addr = addr;
        StWbSend: begin
          bus.ram_rd_addr   = addr;
          bus.mem_out_valid = 1'b1;
          bus.mem_out_data  = out_q;
          bus.mem_out_last  = (cnt_q == CntLast);
        end
        StDone:  bus.done = 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_cache_line_mover.sv
// Randomized bench for cache_line_mover: a RAM model, a line-level reference memory,
// and a negedge monitor that logs writes, output beats and done pulses.
module tb_cache_line_mover;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned OB = 2;
  localparam int unsigned WORDS = 1 << OB;
  localparam int unsigned NLINES = 1 << (AW - OB);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cache_line_mover_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .OFFSET_BITS(OB)) bus ();

  cache_line_mover #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .OFFSET_BITS(OB)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_total = 0;
  int n_bad = 0;
  int cyc = 0;

  logic [DW-1:0] ram_arr [1 << AW];
  logic [DW-1:0] ref_mem [1 << AW];
  bit            line_ok [NLINES];
  logic [DW-1:0] fill_words [WORDS];

  logic [AW-1:0] wr_addr_q [$];
  logic [DW-1:0] wr_data_q [$];
  logic [3:0]    wr_be_q [$];
  int            wr_cyc_q [$];
  logic [DW-1:0] out_data_q [$];
  logic          out_last_q [$];
  int            out_cyc_q [$];
  int            done_cnt = 0;
  int            done_cyc = 0;
  int            hs_cyc = 0;

  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data;
  logic          prev_last;
  logic [AW-1:0] prev_rd_addr;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.ram_wr_en) ram_arr[bus.ram_wr_addr] <= bus.ram_wr_data;
    bus.ram_rd_data <= ram_arr[bus.ram_rd_addr];
  end

  always @(negedge clk) begin
    if (bus.ram_wr_en) begin
      wr_addr_q.push_back(bus.ram_wr_addr);
      wr_data_q.push_back(bus.ram_wr_data);
      wr_be_q.push_back(bus.ram_wr_byte_en);
      wr_cyc_q.push_back(cyc);
    end
    if (bus.req_valid && bus.req_ready) hs_cyc = cyc;
    if (bus.mem_out_valid && bus.mem_out_ready) begin
      out_data_q.push_back(bus.mem_out_data);
      out_last_q.push_back(bus.mem_out_last);
      out_cyc_q.push_back(cyc);
    end
    if (bus.done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (prev_stall && rst_n) begin
      check_eq("stall_valid", 64'(bus.mem_out_valid), 64'(1));
      check_eq("stall_data", 64'(bus.mem_out_data), 64'(prev_data));
      check_eq("stall_last", 64'(bus.mem_out_last), 64'(prev_last));
      check_eq("stall_rd_addr", 64'(bus.ram_rd_addr), 64'(prev_rd_addr));
    end
    prev_stall   = bus.mem_out_valid && !bus.mem_out_ready && rst_n;
    prev_data    = bus.mem_out_data;
    prev_last    = bus.mem_out_last;
    prev_rd_addr = bus.ram_rd_addr;
  end

  task automatic clear_logs();
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_be_q.delete();
    wr_cyc_q.delete();
    out_data_q.delete();
    out_last_q.delete();
    out_cyc_q.delete();
    done_cnt = 0;
  endtask

  task automatic issue_req(input logic op, input int line, output int start);
    clear_logs();
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_line  = 3'(line);
    @(negedge clk); #1;
    check_eq("req_ready_idle", 64'(bus.req_ready), 64'(1));
    start = cyc;
    @(posedge clk); #1;
  endtask

  task automatic randomize_busy_inputs();
    bus.req_valid = 1'($urandom_range(1));
    bus.req_op    = 1'($urandom_range(1));
    bus.req_line  = 3'($urandom);
  endtask

  // gap_pct < 0 selects the fixed valid pattern 1,0,0,1,1,0,1.
  task automatic do_refill(input int line, input int gap_pct, input bit preset);
    int start;
    int idx = 0;
    bit v;
    bit vpat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    if (!preset) for (int i = 0; i < WORDS; i++) fill_words[i] = $urandom;
    issue_req(1'b0, line, start);
    for (int t = 0; t < 200 && done_cnt == 0; t++) begin
      randomize_busy_inputs();
      if (gap_pct < 0) v = (idx < WORDS) && (t >= 7 || vpat[t]);
      else v = (idx < WORDS) && ($urandom_range(99) >= gap_pct);
      bus.mem_in_valid = v;
      bus.mem_in_data  = v ? fill_words[idx] : DW'($urandom);
      @(negedge clk); #1;
      if (v) idx++;
      check_eq("fill_busy_rdy", 64'(bus.req_ready), 64'(0));
      @(posedge clk); #1;
    end
    bus.req_valid    = 1'b0;
    bus.mem_in_valid = 1'b0;
    check_eq("fill_done_cnt", 64'(done_cnt), 64'(1));
    check_eq("fill_wr_cnt", 64'(wr_addr_q.size()), 64'(WORDS));
    for (int i = 0; i < WORDS && i < wr_addr_q.size(); i++) begin
      check_eq("fill_addr", 64'(wr_addr_q[i]), 64'(line * WORDS + i));
      check_eq("fill_data", 64'(wr_data_q[i]), 64'(fill_words[i]));
      check_eq("fill_be", 64'(wr_be_q[i]), 64'(4'hF));
      if (gap_pct == 0) check_eq("fill_beat_cyc", 64'(wr_cyc_q[i] - start), 64'(i + 1));
    end
    if (wr_cyc_q.size() == WORDS)
      check_eq("fill_done_after_last", 64'(done_cyc), 64'(wr_cyc_q[WORDS-1] + 1));
    if (gap_pct == 0) check_eq("fill_done_lat", 64'(done_cyc - start), 64'(WORDS + 1));
    check_eq("fill_ready_after", 64'(bus.req_ready), 64'(1));
    for (int i = 0; i < WORDS; i++) ref_mem[line * WORDS + i] = fill_words[i];
    line_ok[line] = 1'b1;
  endtask

  task automatic do_wb(input int line, input int stall_pct, input int stall_beat);
    int start;
    int stalled = 0;
    issue_req(1'b1, line, start);
    for (int t = 0; t < 300 && done_cnt == 0; t++) begin
      randomize_busy_inputs();
      bus.mem_in_valid = 1'($urandom_range(1));
      bus.mem_in_data  = DW'($urandom);
      if (stall_beat >= 0)
        bus.mem_out_ready = !(out_data_q.size() == stall_beat && stalled < 5);
      else
        bus.mem_out_ready = ($urandom_range(99) >= stall_pct);
      @(negedge clk); #1;
      if (bus.mem_out_valid && !bus.mem_out_ready) stalled++;
      check_eq("wb_busy_rdy", 64'(bus.req_ready), 64'(0));
      @(posedge clk); #1;
    end
    bus.req_valid     = 1'b0;
    bus.mem_in_valid  = 1'b0;
    bus.mem_out_ready = 1'b0;
    check_eq("wb_done_cnt", 64'(done_cnt), 64'(1));
    check_eq("wb_no_writes", 64'(wr_addr_q.size()), 64'(0));
    check_eq("wb_beat_cnt", 64'(out_data_q.size()), 64'(WORDS));
    for (int i = 0; i < WORDS && i < out_data_q.size(); i++) begin
      check_eq("wb_data", 64'(out_data_q[i]), 64'(ref_mem[line * WORDS + i]));
      check_eq("wb_last", 64'(out_last_q[i]), 64'(i == WORDS - 1));
      if (stall_pct == 0 && stall_beat < 0)
        check_eq("wb_beat_cyc", 64'(out_cyc_q[i] - start), 64'(3 + 3 * i));
    end
    if (out_cyc_q.size() == WORDS)
      check_eq("wb_done_after_last", 64'(done_cyc), 64'(out_cyc_q[WORDS-1] + 1));
    if (stall_pct == 0 && stall_beat < 0)
      check_eq("wb_done_lat", 64'(done_cyc - start), 64'(3 * WORDS + 1));
    if (stall_beat >= 0) check_eq("wb_stall_cycles", 64'(stalled), 64'(5));
    check_eq("wb_ready_after", 64'(bus.req_ready), 64'(1));
  endtask

  task automatic do_reset_mid(input int line);
    int start;
    for (int i = 0; i < WORDS; i++) fill_words[i] = $urandom;
    issue_req(1'b0, line, start);
    bus.req_valid = 1'b0;
    for (int b = 0; b < 3; b++) begin
      bus.mem_in_valid = 1'b1;
      bus.mem_in_data  = fill_words[b];
      if (b == 2) rst_n = 1'b0;
      @(negedge clk); #1;
      if (b == 2)
        check_eq("rst_mid_ctrl", 64'({bus.req_ready, bus.done, bus.mem_in_ready,
                                      bus.mem_out_valid, bus.ram_wr_en}), 64'(0));
      @(posedge clk); #1;
    end
    rst_n = 1'b1;
    bus.mem_in_valid = 1'b0;
    #1;
    check_eq("rst_mid_idle", 64'(bus.req_ready), 64'(1));
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_mid_no_done", 64'(done_cnt), 64'(0));
    check_eq("rst_mid_wr_cnt", 64'(wr_addr_q.size()), 64'(2));
    for (int i = 0; i < 2 && i < wr_addr_q.size(); i++) begin
      check_eq("rst_mid_addr", 64'(wr_addr_q[i]), 64'(line * WORDS + i));
      check_eq("rst_mid_data", 64'(wr_data_q[i]), 64'(fill_words[i]));
    end
    for (int i = 0; i < 2; i++) ref_mem[line * WORDS + i] = fill_words[i];
  endtask

  initial begin
    bus.req_valid     = 1'b1;
    bus.req_op        = 1'b0;
    bus.req_line      = '0;
    bus.mem_in_valid  = 1'b1;
    bus.mem_in_data   = 32'hDEADBEEF;
    bus.mem_out_ready = 1'b1;
    clear_logs();

    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      check_eq("rst_ctrl", 64'({bus.req_ready, bus.done, bus.mem_in_ready, bus.mem_out_valid,
                                bus.ram_wr_en, bus.mem_out_last}), 64'(0));
      check_eq("rst_data", 64'({bus.ram_wr_data, bus.mem_out_data}), 64'(0));
      check_eq("rst_addr", 64'({bus.ram_wr_addr, bus.ram_wr_byte_en, bus.ram_rd_addr}), 64'(0));
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      check_eq("idle_rdy", 64'(bus.req_ready), 64'(1));
      check_eq("idle_no_wr", 64'({bus.ram_wr_en, bus.mem_in_ready, bus.done}), 64'(0));
      @(posedge clk); #1;
    end
    bus.mem_in_valid  = 1'b0;
    bus.mem_out_ready = 1'b0;
    check_eq("idle_wr_log", 64'(wr_addr_q.size()), 64'(0));

    fill_words = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
    do_refill(3, 0, 1'b1);
    do_refill(2, -1, 1'b0);
    fill_words = '{32'h11, 32'h22, 32'h33, 32'h44};
    do_refill(7, 0, 1'b1);
    do_wb(7, 0, -1);
    do_wb(7, 0, 2);

    for (int l = 0; l < NLINES; l++)
      if (!line_ok[l]) do_refill(l, int'($urandom_range(50)), 1'b0);

    do_reset_mid(5);
    do_wb(5, 0, -1);

    for (int n = 0; n < 40; n++) begin
      int line = int'($urandom_range(NLINES - 1));
      int pct = ($urandom_range(3) == 0) ? 0 : int'($urandom_range(60));
      if ($urandom_range(1) == 1 && line_ok[line]) do_wb(line, pct, -1);
      else do_refill(line, pct, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
